// File: rtl/tpu_pkg.sv
// Shared widths, operand/accumulator types and saturation limits for the TPU MAC cell.
// The limits only take effect in builds with TPUMAC_SATURATE_EN defined.
package tpu_pkg;

    localparam int unsigned BITS_AB = 8;
    localparam int unsigned BITS_C  = 16;

    typedef logic signed [BITS_AB-1:0] ab_t;
    typedef logic signed [BITS_C-1:0]  c_t;

    localparam c_t C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam c_t C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

endpackage

// File: rtl/tpu_mac_addsat.sv
// Combinational accumulator adder: acc + prod, with optional clamping to C_MAX/C_MIN.
// The ovf output flags signed overflow of the raw sum, whether or not clamping is enabled.
module tpu_mac_addsat
    import tpu_pkg::*;
(
    input  c_t   acc,
    input  c_t   prod,
    input  logic sat_en,
    output c_t   sum,
    output logic ovf
);

    c_t raw;

    always_comb begin
        raw = acc + prod;
        // Overflow: both addends agree in sign but the raw sum does not.
        ovf = (acc[BITS_C-1] == prod[BITS_C-1]) && (raw[BITS_C-1] != acc[BITS_C-1]);
        sum = raw;
        if (sat_en && ovf) begin
            sum = acc[BITS_C-1] ? C_MIN : C_MAX;
        end
    end

endmodule

// File: rtl/tpu_mac_cell.sv
// One systolic-array processing element: passes A east and B south, accumulates A*B into C.
// Define TPUMAC_SATURATE_EN to clamp the accumulator and add the sticky sat output.
module tpu_mac_cell #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned BITS_C  = tpu_pkg::BITS_C
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
`ifdef TPUMAC_SATURATE_EN
    ,
    output logic                      sat
`endif
);

    import tpu_pkg::*;

`ifdef TPUMAC_SATURATE_EN
    localparam logic SatEn = 1'b1;
`else
    localparam logic SatEn = 1'b0;
`endif

    logic signed [BITS_AB-1:0] a_q, b_q;
    logic signed [BITS_C-1:0]  c_q, c_d;
    logic signed [BITS_C-1:0]  prod;
    logic signed [BITS_C-1:0]  acc_next;
    logic                      ovf;

    // Sign-extend before multiplying; the full 8x8 product always fits in BITS_C.
    assign prod = BITS_C'(Ain) * BITS_C'(Bin);

    tpu_mac_addsat u_addsat (
        .acc    (c_q),
        .prod   (prod),
        .sat_en (SatEn),
        .sum    (acc_next),
        .ovf    (ovf)
    );

    always_comb begin
        c_d = acc_next;
        if (WrEn) begin
            c_d = Cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (en) begin
            a_q <= Ain;
            b_q <= Bin;
            c_q <= c_d;
        end
    end

`ifdef TPUMAC_SATURATE_EN
    logic sat_q, sat_d;

    // Sticky until the next load or reset.
    always_comb begin
        sat_d = sat_q | ovf;
        if (WrEn) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (en) begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

    assign Aout = a_q;
    assign Bout = b_q;
    assign Cout = c_q;

endmodule

// File: tb/tb_tpu_mac_cell.sv
// Scoreboard bench for tpu_mac_cell: driver pushes reference-model results, monitor compares.
// Honours TPUMAC_SATURATE_EN to match the DUT build.
module tb_tpu_mac_cell;

    logic               clk;
    logic               rst;
    logic               en;
    logic               WrEn;
    logic signed [7:0]  Ain;
    logic signed [7:0]  Bin;
    logic signed [15:0] Cin;
    logic signed [7:0]  Aout;
    logic signed [7:0]  Bout;
    logic signed [15:0] Cout;
`ifdef TPUMAC_SATURATE_EN
    logic               sat;
`endif

    tpu_mac_cell dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (WrEn),
        .Ain  (Ain),
        .Bin  (Bin),
        .Cin  (Cin),
        .Aout (Aout),
        .Bout (Bout),
`ifdef TPUMAC_SATURATE_EN
        .Cout (Cout),
        .sat  (sat)
`else
        .Cout (Cout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        logic        s;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state as plain integers.
    int m_a = 0, m_b = 0, m_c = 0;
    bit m_sat = 1'b0;

    function automatic int wrap16(int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic step(input bit r, input bit e, input bit w,
                        input int a, input int b, input int c, input string tag);
        int s;
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        WrEn = w;
        Ain  = 8'(a);
        Bin  = 8'(b);
        Cin  = 16'(c);
        if (r) begin
            m_a = 0; m_b = 0; m_c = 0; m_sat = 1'b0;
        end else if (e) begin
            m_a = a;
            m_b = b;
            if (w) begin
                m_c   = c;
                m_sat = 1'b0;
            end else begin
                s = m_c + a * b;
`ifdef TPUMAC_SATURATE_EN
                if (s > 32767) begin
                    s = 32767; m_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768; m_sat = 1'b1;
                end
`else
                s = wrap16(s);
`endif
                m_c = s;
            end
        end
        x.a = 8'(m_a);
        x.b = 8'(m_b);
        x.c = 16'(m_c);
        x.s = m_sat;
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a result one edge after the driven inputs.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (Aout !== x.a || Bout !== x.b || Cout !== x.c
`ifdef TPUMAC_SATURATE_EN
                    || sat !== x.s
`endif
                   ) begin
                    errors++;
`ifdef TPUMAC_SATURATE_EN
                    $display("FAIL %s: got A=%h B=%h C=%h sat=%b expected A=%h B=%h C=%h sat=%b",
                             x.tag, Aout, Bout, Cout, sat, x.a, x.b, x.c, x.s);
`else
                    $display("FAIL %s: got A=%h B=%h C=%h expected A=%h B=%h C=%h",
                             x.tag, Aout, Bout, Cout, x.a, x.b, x.c);
`endif
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; en = 1'b0; WrEn = 1'b0; Ain = '0; Bin = '0; Cin = '0;

        // Reset with arbitrary inputs and en=1.
        step(1, 1, 0, rnd8(), rnd8(), rnd16(), "reset");
        settle();
        chk("reset_c", Cout, 16'h0000);
        chk("reset_a", {8'h00, Aout}, 16'h0000);

        // Reset mid-accumulation.
        for (int i = 0; i < 5; i++) step(0, 1, 0, rnd8(), rnd8(), rnd16(), "pre_reset_acc");
        step(1, 1, 1, rnd8(), rnd8(), rnd16(), "reset_mid");
        settle();
        chk("reset_mid_c", Cout, 16'h0000);

        // Sequential accumulate: sum of i*j over 1..10 = 3025.
        for (int i = 1; i <= 10; i++)
            for (int j = 1; j <= 10; j++) step(0, 1, 0, i, j, rnd16(), "seq");
        settle();
        chk("seq_final", Cout, 16'd3025);

        // Load then signed accumulate.
        step(0, 1, 1, rnd8(), rnd8(), 16'h1234, "load");
        settle();
        chk("load_c", Cout, 16'h1234);
        step(0, 1, 0, -3, 4, rnd16(), "load_acc");
        settle();
        chk("load_acc_c", Cout, 16'h1228);

        // Enable hold.
        step(0, 1, 1, 0, 0, 0, "hold_clear");
        step(0, 1, 0, 5, 10, 0, "hold_acc");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 7, 999, "hold");
        settle();
        chk("hold_c", Cout, 16'd50);
        chk("hold_a", {8'h00, Aout}, 16'h0005);
        chk("hold_b", {8'h00, Bout}, 16'h000a);

        // Overflow on positive accumulate.
        step(0, 1, 1, 0, 0, 16'h7FF0, "wrap_load");
        step(0, 1, 0, 127, 127, 0, "wrap");
        settle();
`ifdef TPUMAC_SATURATE_EN
        chk("sat_c", Cout, 16'h7FFF);
        chk("sat_flag", {15'd0, sat}, 16'h0001);
`else
        chk("wrap_c", Cout, 16'hBEF1);
`endif
        step(0, 1, 1, 0, 0, 0, "neg_load");
        step(0, 1, 0, -128, -128, 0, "neg_neg");
        settle();
        chk("neg_neg_c", Cout, 16'd16384);
        step(0, 1, 0, -1, 2, 0, "sign");
        settle();
        chk("sign_c", Cout, 16'd16382);

        // Random traffic.
        for (int i = 0; i < 500; i++)
            step(0, 1'($urandom_range(1)), (i % 20) == 0, rnd8(), rnd8(), rnd16(), "random");

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
